// File: rtl/l1a_trigger_scheduler.sv
// L1A trigger scheduler: merges external and periodic self triggers, applies
// prescale and deadtime, and keeps L1A requests out of the BCR (bcid == 0) slot.
module l1a_trigger_scheduler (
    input  logic        clk40,
    input  logic        rstn,
    input  logic        enable,
    input  logic        extTrig,
    input  logic        selfTrigEn,
    input  logic [15:0] selfTrigPeriod,
    input  logic [7:0]  prescale,
    input  logic [7:0]  deadtime,
    input  logic        clrCounters,
    output logic        trig,
    output logic [11:0] bcid,
    output logic [31:0] trigCount,
    output logic [15:0] droppedCount
);

    // state   | meaning
    // IDLE    | disabled; requests ignored, prescale/deadtime counters cleared
    // ARMED   | requests advance the prescale counter; a grant issues trig
    // PENDING | grant landed on the BCR slot; trig goes out one cycle later
    // HOLDOFF | deadtime veto running; requests are dropped
    typedef enum logic [1:0] {IDLE, ARMED, PENDING, HOLDOFF} stateT;

    localparam logic [11:0] BCID_MAX = 12'd3563;

    stateT       state, stateNext;
    logic        sync0, sync1, sync2;
    logic [15:0] selfCnt;
    logic [7:0]  preCnt, preCntNext;
    logic [7:0]  dtCnt, dtCntNext;
    logic        trigNext;
    logic        dropEv;
    logic        extReq, selfActive, selfReq, req;

    assign extReq     = sync1 & ~sync2;
    assign selfActive = selfTrigEn & enable & (selfTrigPeriod != 16'd0);
    assign selfReq    = selfActive & (selfCnt == selfTrigPeriod - 16'd1);
    assign req        = extReq | selfReq;

    always_comb begin
        stateNext  = state;
        preCntNext = preCnt;
        dtCntNext  = dtCnt;
        trigNext   = 1'b0;
        dropEv     = 1'b0;
        case (state)
            IDLE: begin
                preCntNext = 8'd0;
                dtCntNext  = 8'd0;
                if (enable)
                    stateNext = ARMED;
            end
            ARMED: begin
                if (!enable) begin
                    stateNext  = IDLE;
                    preCntNext = 8'd0;
                end else if (req) begin
                    if (preCnt == prescale) begin
                        preCntNext = 8'd0;
                        // trig must not land on bcid 0, so defer it by one cycle
                        if (bcid == BCID_MAX) begin
                            stateNext = PENDING;
                        end else begin
                            trigNext = 1'b1;
                            if (deadtime != 8'd0) begin
                                stateNext = HOLDOFF;
                                dtCntNext = deadtime;
                            end
                        end
                    end else begin
                        preCntNext = preCnt + 8'd1;
                    end
                end
            end
            PENDING: begin
                if (!enable) begin
                    stateNext  = IDLE;
                    preCntNext = 8'd0;
                    dropEv     = 1'b1;
                end else begin
                    trigNext  = 1'b1;
                    dropEv    = req;
                    dtCntNext = deadtime;
                    stateNext = (deadtime == 8'd0) ? ARMED : HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (!enable) begin
                    stateNext  = IDLE;
                    preCntNext = 8'd0;
                    dtCntNext  = 8'd0;
                end else begin
                    dropEv = req;
                    if (dtCnt <= 8'd1) begin
                        stateNext = ARMED;
                        dtCntNext = 8'd0;
                    end else begin
                        dtCntNext = dtCnt - 8'd1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk40) begin
        if (!rstn) begin
            state        <= IDLE;
            trig         <= 1'b0;
            bcid         <= 12'd0;
            trigCount    <= 32'd0;
            droppedCount <= 16'd0;
            sync0        <= 1'b0;
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            selfCnt      <= 16'd0;
            preCnt       <= 8'd0;
            dtCnt        <= 8'd0;
        end else begin
            state  <= stateNext;
            trig   <= trigNext;
            preCnt <= preCntNext;
            dtCnt  <= dtCntNext;
            sync0  <= extTrig;
            sync1  <= sync0;
            sync2  <= sync1;
            bcid   <= (bcid == BCID_MAX) ? 12'd0 : bcid + 12'd1;

            if (!selfActive || selfReq)
                selfCnt <= 16'd0;
            else
                selfCnt <= selfCnt + 16'd1;

            // clear wins over a coincident increment
            if (clrCounters)
                trigCount <= 32'd0;
            else if (trig)
                trigCount <= trigCount + 32'd1;

            if (clrCounters)
                droppedCount <= 16'd0;
            else if (dropEv && droppedCount != 16'hFFFF)
                droppedCount <= droppedCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_l1a_trigger_scheduler.sv
// Bench for l1a_trigger_scheduler: directed scenarios plus randomized traffic,
// all compared every cycle against an event-time reference model.
`timescale 1ns/1ps
module tb_l1a_trigger_scheduler;

    logic        clk40 = 1'b0;
    logic        rstn, enable, extTrig, selfTrigEn, clrCounters;
    logic [15:0] selfTrigPeriod;
    logic [7:0]  prescale, deadtime;
    logic        trig;
    logic [11:0] bcid;
    logic [31:0] trigCount;
    logic [15:0] droppedCount;

    l1a_trigger_scheduler dut (
        .clk40(clk40), .rstn(rstn), .enable(enable), .extTrig(extTrig),
        .selfTrigEn(selfTrigEn), .selfTrigPeriod(selfTrigPeriod),
        .prescale(prescale), .deadtime(deadtime), .clrCounters(clrCounters),
        .trig(trig), .bcid(bcid), .trigCount(trigCount), .droppedCount(droppedCount)
    );

    always #12 clk40 = ~clk40;

    int checks = 0;
    int errors = 0;

    // requested inputs for the next cycle
    logic        dRstn = 1'b0, dEnable = 1'b0, dExt = 1'b0, dSelfEn = 1'b0, dClr = 1'b0;
    logic [15:0] dPeriod = 16'd0;
    logic [7:0]  dPrescale = 8'd0, dDeadtime = 8'd0;

    // reference model: cycle index, scheduled trig cycle, veto end, request tally
    int          n = 0;
    int          tSched = -1;
    int          vetoEnd = 0;
    int          seen = 0;
    int          runLen = 0;
    int          mBcid = 0;
    int          mDrop = 0;
    logic [31:0] mTrigCnt = 32'd0;
    bit          armed = 1'b0;
    bit          e1 = 1'b0, e2 = 1'b0, e3 = 1'b0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    task automatic modelStep();
        bit trigNow, extReq, selfAct, selfReq, req, drop;
        int nextBcid, t;
        trigNow = (tSched == n);
        if (!dRstn) begin
            mBcid = 0; mTrigCnt = 32'd0; mDrop = 0; tSched = -1; vetoEnd = 0;
            seen = 0; armed = 1'b0; e1 = 1'b0; e2 = 1'b0; e3 = 1'b0; runLen = 0;
        end else begin
            extReq   = e2 & ~e3;
            selfAct  = dSelfEn && dEnable && (dPeriod != 16'd0);
            selfReq  = selfAct && ((runLen % int'(dPeriod)) == int'(dPeriod) - 1);
            req      = extReq | selfReq;
            drop     = 1'b0;
            nextBcid = (mBcid + 1) % 3564;
            if (armed) begin
                if (!dEnable) begin
                    if (tSched > n) begin
                        tSched = -1;
                        drop = 1'b1;
                    end
                    seen = 0;
                    vetoEnd = 0;
                end else if (req) begin
                    if (n < vetoEnd) begin
                        drop = 1'b1;
                    end else if (seen == int'(dPrescale)) begin
                        seen = 0;
                        t = (nextBcid == 0) ? n + 2 : n + 1;
                        tSched = t;
                        vetoEnd = t + int'(dDeadtime);
                    end else begin
                        seen++;
                    end
                end
            end else begin
                seen = 0;
                vetoEnd = 0;
            end
            if (dClr) begin
                mTrigCnt = 32'd0;
                mDrop = 0;
            end else begin
                if (trigNow) mTrigCnt = mTrigCnt + 32'd1;
                if (drop && mDrop < 65535) mDrop++;
            end
            runLen = selfAct ? runLen + 1 : 0;
            e3 = e2; e2 = e1; e1 = dExt;
            armed = dEnable;
            mBcid = nextBcid;
        end
        n++;
    endtask

    task automatic applyInputs();
        rstn = dRstn; enable = dEnable; extTrig = dExt; selfTrigEn = dSelfEn;
        clrCounters = dClr; selfTrigPeriod = dPeriod; prescale = dPrescale;
        deadtime = dDeadtime;
    endtask

    task automatic tick();
        @(negedge clk40);
        checkVal("trig", 32'(trig), 32'(tSched == n));
        checkVal("bcid", 32'(bcid), 32'(mBcid));
        checkVal("trigCount", trigCount, mTrigCnt);
        checkVal("droppedCount", 32'(droppedCount), 32'(mDrop));
        applyInputs();
        modelStep();
    endtask

    task automatic runN(input int k);
        repeat (k) tick();
    endtask

    task automatic doReset();
        dRstn = 1'b0; dEnable = 1'b0; dExt = 1'b0; dClr = 1'b0; dSelfEn = 1'b0;
        tick();
        tick();
        dRstn = 1'b1;
    endtask

    initial begin
        applyInputs();

        // reset state and single external trigger latency
        doReset();
        checkVal("reset_bcid", 32'(bcid), 32'd0);
        checkVal("reset_trig", 32'(trig), 32'd0);
        dEnable = 1'b1; dPrescale = 8'd0; dDeadtime = 8'd0;
        runN(99);
        dExt = 1'b1;
        runN(3);
        dExt = 1'b0;
        runN(20);
        checkVal("ext_single_count", trigCount, 32'd1);

        // self trigger with prescale over 1000 cycles
        doReset();
        dEnable = 1'b1; dSelfEn = 1'b1; dPeriod = 16'd10; dPrescale = 8'd2; dDeadtime = 8'd0;
        runN(1000);
        checkVal("self_prescale_count", trigCount, 32'd33);

        // deadtime drops every other of four pulses
        doReset();
        dEnable = 1'b1; dPrescale = 8'd0; dDeadtime = 8'd5;
        runN(20);
        for (int i = 0; i < 4; i++) begin
            dExt = 1'b1;
            tick();
            dExt = 1'b0;
            runN(2);
        end
        runN(20);
        checkVal("deadtime_trig_count", trigCount, 32'd2);
        checkVal("deadtime_drop_count", 32'(droppedCount), 32'd2);

        // grant aimed at the BCR slot is deferred to bcid 1
        doReset();
        dEnable = 1'b1; dSelfEn = 1'b1; dPeriod = 16'd12; dPrescale = 8'd0; dDeadtime = 8'd3;
        runN(3566);
        checkVal("bcr_defer_trig", 32'(trig), 32'd1);
        checkVal("bcr_defer_bcid", 32'(bcid), 32'd1);
        runN(10);

        // droppedCount saturation, then clear
        doReset();
        dEnable = 1'b1; dSelfEn = 1'b1; dPeriod = 16'd1; dPrescale = 8'd0; dDeadtime = 8'd255;
        runN(66200);
        checkVal("drop_saturated", 32'(droppedCount), 32'h0000FFFF);
        runN(10);
        checkVal("drop_still_saturated", 32'(droppedCount), 32'h0000FFFF);
        dClr = 1'b1;
        tick();
        dClr = 1'b0;
        tick();
        checkVal("clr_trigCount", trigCount, 32'd0);
        checkVal("clr_droppedCount", 32'(droppedCount), 32'd0);
        dSelfEn = 1'b0; dDeadtime = 8'd0;

        // reset during holdoff with an external edge in flight
        doReset();
        dEnable = 1'b1; dPrescale = 8'd0; dDeadtime = 8'd20;
        runN(10);
        dExt = 1'b1;
        tick();
        dExt = 1'b0;
        runN(4);
        dExt = 1'b1;
        tick();
        dExt = 1'b0;
        dRstn = 1'b0;
        tick();
        tick();
        checkVal("rst_abort_trig", 32'(trig), 32'd0);
        checkVal("rst_abort_bcid", 32'(bcid), 32'd0);
        checkVal("rst_abort_trigCount", trigCount, 32'd0);
        checkVal("rst_abort_drop", 32'(droppedCount), 32'd0);
        dRstn = 1'b1;
        runN(20);
        checkVal("rst_abort_no_trig", trigCount, 32'd0);

        // randomized traffic; configuration changes only while disabled
        for (int seg = 0; seg < 22; seg++) begin
            dEnable = 1'b0; dClr = 1'b0; dRstn = 1'b1;
            runN(3);
            dPrescale = 8'($urandom_range(0, 3));
            dDeadtime = 8'($urandom_range(0, 6));
            dPeriod   = 16'($urandom_range(0, 9));
            dSelfEn   = 1'($urandom_range(0, 1));
            tick();
            dEnable = 1'b1;
            repeat (200) begin
                dExt = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 60) == 0) dEnable = ~dEnable;
                dClr  = ($urandom_range(0, 80) == 0);
                dRstn = ($urandom_range(0, 2000) != 0);
                tick();
            end
        end
        dRstn = 1'b1; dClr = 1'b0; dExt = 1'b0;
        runN(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l1a_trigger_scheduler.md
L1A_TRIGGER_SCHEDULER -- requirements
Module: l1a_trigger_scheduler

Interface
REQ-001 clk40  in  1  40 MHz system clock; all logic on its rising edge.
REQ-002 rstn  in  1  reset, synchronous, active-low.
REQ-003 enable  in  1  scheduler run enable (level).
REQ-004 extTrig  in  1  asynchronous external trigger (beam scintillator), level.
REQ-005 selfTrigEn  in  1  enables internal periodic trigger source.
REQ-006 selfTrigPeriod  in  16  self-trigger period in clk40 cycles; 0 = self source off.
REQ-007 prescale  in  8  accept 1 of every (prescale+1) requests.
REQ-008 deadtime  in  8  veto window in cycles after each issued trigger.
REQ-009 clrCounters  in  1  one-cycle pulse, clears trigCount and droppedCount.
REQ-010 trig  out  1  one-cycle L1A request pulse to the fast command controller trig input.
REQ-011 bcid  out  12  free-running bunch-crossing counter.
REQ-012 trigCount  out  32  issued triggers.
REQ-013 droppedCount  out  16  requests lost to deadtime/deferral.

Function
REQ-014 extTrig SHALL pass a 2-flop synchronizer plus a third history flop; extReq = sync1 & ~sync2 (rising edge only).
REQ-015 extTrig first sampled high at edge k SHALL, absent veto/prescale, produce trig high for exactly the cycle after edge k+2.
REQ-016 Self source: counter 0..selfTrigPeriod-1, selfReq in the cycle count == selfTrigPeriod-1, then wrap to 0; held at 0 when selfTrigEn=0, selfTrigPeriod=0 or enable=0.
REQ-017 extReq and selfReq in the same cycle SHALL count as one request.
REQ-018 bcid SHALL count 0..3563 and wrap to 0, running regardless of enable.
REQ-019 FSM states: IDLE, ARMED, PENDING, HOLDOFF.
REQ-020 IDLE: enable=0; requests ignored, not counted; prescale/deadtime counters held at 0. enable=1 -> ARMED next edge.
REQ-021 ARMED: each request increments prescale counter; when counter == prescale the request is granted and counter returns to 0.
REQ-022 Grant SHALL register trig=1 next edge unless that cycle's bcid would be 0 (BCR slot); then -> PENDING and trig issued one cycle later.
REQ-023 After trig with deadtime=0 -> stay ARMED (back-to-back triggers allowed); deadtime=D>0 -> HOLDOFF for exactly D cycles, then ARMED.
REQ-024 Requests arriving in PENDING or HOLDOFF SHALL be dropped, increment droppedCount, and not advance the prescale counter.
REQ-025 enable falling in any state -> IDLE next edge; a PENDING trigger is discarded and counted dropped.
REQ-026 trigCount SHALL increment on every cycle trig=1 and wrap at 2^32; droppedCount SHALL saturate at 16'hFFFF.
REQ-027 clrCounters SHALL zero both counters next edge; a simultaneous increment is lost (clear wins).
REQ-028 trig SHALL never be high in a cycle where bcid == 0, nor in two consecutive cycles when deadtime>0.

Reset
REQ-029 rstn=0 at an edge SHALL set state IDLE, trig=0, bcid=0, trigCount=0, droppedCount=0, all synchronizer, prescale, deadtime and self counters 0.
REQ-030 Reset asserted mid-HOLDOFF or PENDING SHALL abort without emitting trig; first trig after release no earlier than REQ-015 latency.

Verification
REQ-031 enable=1, prescale=0, deadtime=0, extTrig 0->1 at edge 100 (bcid!=0) -> trig high only in cycle after edge 102; trigCount=1.
REQ-032 selfTrigEn=1, period=10, prescale=2, 1000 cycles -> trig every 30 cycles (except BCR deferrals), trigCount=33.
REQ-033 deadtime=5, ext pulses 3 cycles apart x4 -> triggers on pulses 1 and 3 only; droppedCount=2.
REQ-034 self request timed so grant targets bcid=0 -> trig appears at bcid=1; deadtime then counted from that cycle.
REQ-035 droppedCount preloaded to 16'hFFFF via long dropped run -> stays 16'hFFFF; clrCounters -> both counters 0 next cycle.
REQ-036 rstn low during HOLDOFF with pending ext edge -> no trig, all outputs 0, bcid restarts at 0.
